// File: rtl/imm_pkg.sv
// Shared types and constants for the RV32I immediate generator.
package imm_pkg;

  // Datapath width of the extended immediate (RV32I).
  localparam int IMM_W = 32;

  // Immediate format select; encodings 3'b101..3'b111 are reserved.
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

endpackage : imm_pkg

// File: rtl/imm_extend_comb.sv
// Combinational immediate reassembly and sign extension.
// Usable on its own by any consumer that needs the immediate unregistered.
module imm_extend_comb
  import imm_pkg::*;
(
  input  logic [31:7]      instr,
  input  imm_src_t         imm_src,
  output logic [IMM_W-1:0] imm_ext
);

  // Select the immediate layout; reserved encodings yield zero, never X.
  always_comb begin
    imm_ext = 32'h0000_0000;
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm_ext = {instr[31:12], 12'h000};
      default: imm_ext = 32'h0000_0000;
    endcase
  end

endmodule : imm_extend_comb

// File: rtl/imm_extend.sv
// Registered immediate generator feeding the ID/EX boundary.
// The extended immediate appears one clock after an enabled capture;
// en low stalls the register and holds the previous value.
module imm_extend
  import imm_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [31:7]      instr,
  input  logic [2:0]       ImmSrc,
  output logic [IMM_W-1:0] ImmExt
);

  logic [IMM_W-1:0] imm_next_s;
  logic [IMM_W-1:0] imm_r;

  imm_extend_comb u_comb (
    .instr   (instr),
    .imm_src (imm_src_t'(ImmSrc)),
    .imm_ext (imm_next_s)
  );

  // Capture the next immediate on enabled edges; clear at once on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_r <= 32'h0000_0000;
    end else if (en) begin
      imm_r <= imm_next_s;
    end else begin
      imm_r <= imm_r;
    end
  end

  assign ImmExt = imm_r;

endmodule : imm_extend

// File: tb/tb_imm_extend.sv
// Self-checking bench for imm_extend: directed vectors plus a random sweep.
module tb_imm_extend;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [31:7] instr;
  logic [2:0]  ImmSrc;
  logic [31:0] ImmExt;

  int total_cnt;
  int bad_cnt;

  imm_extend dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .instr   (instr),
    .ImmSrc  (ImmSrc),
    .ImmExt  (ImmExt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference immediate built straight from the format table.
  function automatic logic [31:0] ref_imm(input logic [31:7] i, input logic [2:0] s);
    logic [31:0] r;
    case (s)
      3'b000:  r = {{20{i[31]}}, i[31:20]};
      3'b001:  r = {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'b100:  r = {i[31:12], 12'h000};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held;

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset_n   = 1'b0;
    en        = 1'b0;
    instr     = 25'h0;
    ImmSrc    = 3'b000;

    #12;
    check_val("reset_state", ImmExt, 32'h0000_0000);
    #2;
    reset_n = 1'b1;
    step();
    check_val("post_reset_idle", ImmExt, 32'h0000_0000);

    // 1: I-type negative
    en = 1'b1;
    instr = 25'h0; instr[31:20] = 12'hFFF; ImmSrc = 3'b000;
    step();
    check_val("i_neg", ImmExt, 32'hFFFF_FFFF);

    // I-type positive
    instr = 25'h0; instr[31:20] = 12'h7FF; ImmSrc = 3'b000;
    step();
    check_val("i_pos", ImmExt, 32'h0000_07FF);

    // 2: S-type negative
    instr = 25'h0; instr[31:25] = 7'b1111111; instr[11:7] = 5'b11100; ImmSrc = 3'b001;
    step();
    check_val("s_neg", ImmExt, 32'hFFFF_FFFC);

    // 3: B-type negative
    instr = 25'h0; instr[31] = 1'b1; instr[7] = 1'b1; instr[30:25] = 6'h3F; instr[11:8] = 4'hC;
    ImmSrc = 3'b010;
    step();
    check_val("b_neg", ImmExt, 32'hFFFF_FFF8);

    // B-type: only bit 7 set lands at result bit 11, LSB stays 0
    instr = 25'h0; instr[7] = 1'b1; ImmSrc = 3'b010;
    step();
    check_val("b_bit11", ImmExt, 32'h0000_0800);

    // 4: J-type, only instr[20]
    instr = 25'h0; instr[20] = 1'b1; ImmSrc = 3'b011;
    step();
    check_val("j_bit11", ImmExt, 32'h0000_0800);

    // J-type: instr[19:12] lands at 19:12, instr[30:21] at 10:1
    instr = 25'h0; instr[19:12] = 8'hA5; instr[30:21] = 10'h3FF; ImmSrc = 3'b011;
    step();
    check_val("j_mix", ImmExt, 32'h000A_57FE);

    // U-type
    instr = 25'h0; instr[31:12] = 20'h12345; ImmSrc = 3'b100;
    step();
    check_val("u_pos", ImmExt, 32'h1234_5000);

    // U-type with bit 31 set: no extension beyond bit 31, low bits zero
    instr = 25'h1FF_FFFF; ImmSrc = 3'b100;
    step();
    check_val("u_neg", ImmExt, 32'hFFFF_F000);

    // Reserved encodings
    instr = 25'h1FF_FFFF; ImmSrc = 3'b111;
    step();
    check_val("rsv_111", ImmExt, 32'h0000_0000);
    ImmSrc = 3'b101;
    step();
    check_val("rsv_101", ImmExt, 32'h0000_0000);
    ImmSrc = 3'b110;
    step();
    check_val("rsv_110", ImmExt, 32'h0000_0000);

    // 5: hold while en low and inputs change
    instr = 25'h0; instr[31:12] = 20'hABCDE; ImmSrc = 3'b100;
    step();
    check_val("hold_load", ImmExt, 32'hABCD_E000);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      instr  = 25'(k * 25'h0AB_CD1 + 25'h155_5555);
      ImmSrc = 3'(k);
      step();
      check_val("hold", ImmExt, 32'hABCD_E000);
    end

    // Reset mid-stream, between edges
    en = 1'b1;
    instr = 25'h0; instr[31:12] = 20'h00F0F; ImmSrc = 3'b100;
    step();
    check_val("pre_rst", ImmExt, 32'h00F0_F000);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_async", ImmExt, 32'h0000_0000);
    step();
    check_val("rst_held", ImmExt, 32'h0000_0000);
    #2;
    reset_n = 1'b1;
    instr = 25'h0; instr[31:20] = 12'hFFF; ImmSrc = 3'b000;
    step();
    check_val("recover", ImmExt, 32'hFFFF_FFFF);

    // 6: random sweep over the valid formats
    for (int n = 0; n < 1000; n++) begin
      instr  = 25'($urandom);
      ImmSrc = 3'($urandom_range(0, 4));
      held   = ref_imm(instr, ImmSrc);
      step();
      check_val("sweep", ImmExt, held);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule : tb_imm_extend

// File: doc/imm_extend.md
Name: imm_extend

Overview:
Immediate generator for the RV32I decode stage.
- Reassembles the immediate field of a 32-bit instruction (bits 31:7) according to the format selected by ImmSrc.
- Sign-extends the result to 32 bits, or zero-fills the low bits for U-type.
- Registers the result, so the extended immediate is presented one clock after capture and feeds the ID/EX boundary.

Parameters:
- None. The data width is fixed at 32 (RV32I).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable. 0 = hold the current output (pipeline stall).
- instr  input  25  instruction bits [31:7]. Declared with that index range, so the field slices below use native instruction bit numbers.
- ImmSrc  input  3  immediate format select.
- ImmExt  output  32  registered extended immediate.

Interface rules:
- One clock domain: clk.
- reset_n is asynchronous assert and active-low.
- Deassertion of reset_n is synchronised externally.

Behaviour:
- ImmSrc encoding, with i = instr:
  - 3'b000 I-type: {{20{i[31]}}, i[31:20]}
  - 3'b001 S-type: {{20{i[31]}}, i[31:25], i[11:7]}
  - 3'b010 B-type: {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}
  - 3'b011 J-type: {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}
  - 3'b100 U-type: {i[31:12], 12'b0}
  - 3'b101, 3'b110, 3'b111 (reserved): 32'h0000_0000. No X propagation.
- Next-value logic is purely combinational from instr and ImmSrc.
- Output register:
  - reset_n low: ImmExt = 0 immediately, independent of clk.
  - Rising clk with reset_n high and en = 1: ImmExt takes the next value. Latency is exactly 1 cycle.
  - Rising clk with en = 0: ImmExt holds its previous value.
- Reset asserted mid-stream forces 0 at once. After release, the first enabled edge loads the current inputs.
- Sign bit is always i[31] for I, S, B and J. U-type is never sign-extended beyond bit 31.
- No arithmetic is performed; the low bit of B and J results is always 0.

Decomposition:
- Shared package imm_pkg:
  - typedef enum logic [2:0] imm_src_t: IMM_I, IMM_S, IMM_B, IMM_J, IMM_U.
  - Constant IMM_W = 32.
- One sub-module: imm_extend_comb.
  - Pure combinational case on imm_src_t.
  - Reused by any unregistered consumer.
- imm_extend instantiates imm_extend_comb plus the reset/enable register.

Test Plan:
1. I-type negative: ImmSrc=000, instr[31:20]=12'hFFF, other bits 0, en=1.
   - After one edge: ImmExt=32'hFFFF_FFFF.
2. S-type negative: ImmSrc=001, instr[31:25]=7'b1111111, instr[11:7]=5'b11100.
   - ImmExt=32'hFFFF_FFFC.
3. B-type negative: ImmSrc=010, instr[31]=1, instr[7]=1, instr[30:25]=6'h3F, instr[11:8]=4'hC.
   - ImmExt=32'hFFFF_FFF8.
4. J-type and U-type:
   - J: ImmSrc=011, only instr[20]=1 → ImmExt=32'h0000_0800.
   - U: ImmSrc=100, instr[31:12]=20'h12345 → ImmExt=32'h1234_5000.
   - Reserved: ImmSrc=111 with any instr → ImmExt=0.
5. Control:
   - Hold: en=0 while inputs change → ImmExt unchanged across 3 edges.
   - Reset mid-stream: assert reset_n=0 between edges → ImmExt=0 without a clock edge.
   - Recovery: release reset, apply case 1 inputs → 32'hFFFF_FFFF after one edge.
6. Sweep: randomised instr across all five valid ImmSrc values, 1000 vectors.
   - Each registered output matches the bit-slice formulas above.
